// File: rtl/rgb_segment_sram_writer.sv
// rgb_segment_sram_writer
//
// Packs a raster-order 24-bit RGB pixel stream into the segmented SRAM
// layout read back by the VGA fetch stage. Every group of 4 pixels
// (P0..P3) becomes 6 word writes:
//   red pairs   {P0.R,P1.R} {P2.R,P3.R} at RED_START   + 2q, 2q+1
//   green pairs {P0.G,P1.G} {P2.G,P3.G} at GREEN_START + 2q, 2q+1
//   blue even   {P0.B,P2.B}             at BLUE_EVEN_START + q
//   blue odd    {P1.B,P3.B}             at BLUE_ODD_START  + q
// The earlier pixel always lands in bits [15:8].
//
// Optional build macro: WRITE_OVERLAP_EN adds a 4-pixel shadow buffer so
// the next quad is collected while the current one is being written.
//
// Ports:
//   Clock_50        system clock, all logic on posedge
//   Resetn          asynchronous active-low reset (aborts any frame)
//   Start           one-cycle pulse, begins a frame fill (ignored unless idle)
//   Pixel_valid     upstream pixel valid
//   Pixel_ready     registered ready towards upstream
//   Pixel_R/G/B     current pixel colour
//   SRAM_address    word address to SRAM_controller
//   SRAM_write_data write data to SRAM_controller
//   SRAM_we_n       active-low write enable to SRAM_controller
//   Busy            high from Start accept until Done
//   Done            one-cycle pulse after the last write of the frame
//   debug_state     current FSM state
//
// Handshake: a pixel moves on every rising edge where Pixel_valid and
// Pixel_ready are both high. Pixel_ready is registered, so it is stable for
// the whole cycle; upstream may raise or drop Pixel_valid at any time and
// must hold the pixel data while Pixel_valid is high and Pixel_ready is low.
module rgb_segment_sram_writer #(
  parameter logic [17:0] RED_START_ADDRESS       = 18'd0,
  parameter logic [17:0] GREEN_START_ADDRESS     = 18'd38400,
  parameter logic [17:0] BLUE_EVEN_START_ADDRESS = 18'd76800,
  parameter logic [17:0] BLUE_ODD_START_ADDRESS  = 18'd96000,
  parameter int          NUM_QUADS               = 19200
) (
  input  logic        Clock_50,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        Pixel_valid,
  output logic        Pixel_ready,
  input  logic [7:0]  Pixel_R,
  input  logic [7:0]  Pixel_G,
  input  logic [7:0]  Pixel_B,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Busy,
  output logic        Done,
  output logic [3:0]  debug_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_COLLECT,
    S_WRITE_0, S_WRITE_1, S_WRITE_2, S_WRITE_3, S_WRITE_4, S_WRITE_5,
    S_FINISH
  } state_t;

  localparam logic [17:0] LAST_QUAD = 18'(NUM_QUADS - 1);

  state_t            state, state_n;
  logic [17:0]       quad_counter, quad_n;
  logic [1:0]        pixel_index, index_n;
  logic [3:0][23:0]  pix, pix_n;          // [23:16]=R [15:8]=G [7:0]=B
  logic [17:0]       addr_n;
  logic [15:0]       data_n;
  logic              we_n_n, ready_n, busy_n, done_n;
  logic [23:0]       pixel_in;
  logic              transfer;
  logic [17:0]       q2;

`ifdef WRITE_OVERLAP_EN
  logic [3:0][23:0]  shadow, shadow_n;
  logic [2:0]        shadow_count, shadow_count_n;
`endif

  assign pixel_in    = {Pixel_R, Pixel_G, Pixel_B};
  assign transfer    = Pixel_valid && Pixel_ready;
  assign q2          = {quad_counter[16:0], 1'b0};
  assign debug_state = state;

  always_comb begin
    state_n = state;
    quad_n  = quad_counter;
    index_n = pixel_index;
    pix_n   = pix;
    addr_n  = SRAM_address;
    data_n  = SRAM_write_data;
    we_n_n  = 1'b1;
    ready_n = Pixel_ready;
    busy_n  = Busy;
    done_n  = 1'b0;
`ifdef WRITE_OVERLAP_EN
    shadow_n       = shadow;
    shadow_count_n = shadow_count;
    // While the current quad is written, the next one fills the shadow.
    // No pixels beyond the final quad are ever accepted.
    if (state inside {S_WRITE_0, S_WRITE_1, S_WRITE_2, S_WRITE_3, S_WRITE_4, S_WRITE_5}) begin
      if (transfer) begin
        shadow_n[shadow_count[1:0]] = pixel_in;
        shadow_count_n              = shadow_count + 3'd1;
      end
      ready_n = (quad_counter != LAST_QUAD) && (shadow_count_n != 3'd4);
    end
`endif

    case (state)
      S_IDLE: begin
        ready_n = 1'b0;
        if (Start) begin
          busy_n  = 1'b1;
          quad_n  = '0;
          index_n = '0;
          ready_n = 1'b1;
          state_n = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (transfer) begin
          pix_n[pixel_index] = pixel_in;
          index_n            = pixel_index + 2'd1;
          if (pixel_index == 2'd3) begin
`ifdef WRITE_OVERLAP_EN
            ready_n = (quad_counter != LAST_QUAD);
`else
            ready_n = 1'b0;
`endif
            index_n = '0;
            state_n = S_WRITE_0;
          end
        end
      end
      S_WRITE_0: begin
        we_n_n  = 1'b0;
        addr_n  = RED_START_ADDRESS + q2;
        data_n  = {pix[0][23:16], pix[1][23:16]};
        state_n = S_WRITE_1;
      end
      S_WRITE_1: begin
        we_n_n  = 1'b0;
        addr_n  = RED_START_ADDRESS + q2 + 18'd1;
        data_n  = {pix[2][23:16], pix[3][23:16]};
        state_n = S_WRITE_2;
      end
      S_WRITE_2: begin
        we_n_n  = 1'b0;
        addr_n  = GREEN_START_ADDRESS + q2;
        data_n  = {pix[0][15:8], pix[1][15:8]};
        state_n = S_WRITE_3;
      end
      S_WRITE_3: begin
        we_n_n  = 1'b0;
        addr_n  = GREEN_START_ADDRESS + q2 + 18'd1;
        data_n  = {pix[2][15:8], pix[3][15:8]};
        state_n = S_WRITE_4;
      end
      S_WRITE_4: begin
        we_n_n  = 1'b0;
        addr_n  = BLUE_EVEN_START_ADDRESS + quad_counter;
        data_n  = {pix[0][7:0], pix[2][7:0]};
        state_n = S_WRITE_5;
      end
      S_WRITE_5: begin
        we_n_n = 1'b0;
        addr_n = BLUE_ODD_START_ADDRESS + quad_counter;
        data_n = {pix[1][7:0], pix[3][7:0]};
        if (quad_counter == LAST_QUAD) begin
          ready_n = 1'b0;
          state_n = S_FINISH;
        end else begin
          quad_n  = quad_counter + 18'd1;
          ready_n = 1'b1;
          state_n = S_COLLECT;
`ifdef WRITE_OVERLAP_EN
          // Hand the shadow over; a full shadow skips the collect cycle.
          pix_n          = shadow_n;
          index_n        = shadow_count_n[1:0];
          shadow_count_n = '0;
          if (shadow_count_n == 3'd4) begin
            state_n = S_WRITE_0;
            ready_n = (quad_n != LAST_QUAD);
          end
`endif
        end
      end
      S_FINISH: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        ready_n = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state           <= S_IDLE;
      quad_counter    <= '0;
      pixel_index     <= '0;
      pix             <= '0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      Pixel_ready     <= 1'b0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
    end else begin
      state           <= state_n;
      quad_counter    <= quad_n;
      pixel_index     <= index_n;
      pix             <= pix_n;
      SRAM_address    <= addr_n;
      SRAM_write_data <= data_n;
      SRAM_we_n       <= we_n_n;
      Pixel_ready     <= ready_n;
      Busy            <= busy_n;
      Done            <= done_n;
    end
  end

`ifdef WRITE_OVERLAP_EN
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      shadow       <= '0;
      shadow_count <= '0;
    end else begin
      shadow       <= shadow_n;
      shadow_count <= shadow_count_n;
    end
  end
`endif

endmodule

// File: tb/tb_rgb_segment_sram_writer.sv
// Testbench for rgb_segment_sram_writer (frame shortened to NQ quads).
module tb_rgb_segment_sram_writer;

  localparam int          NQ  = 48;
  localparam logic [17:0] RED = 18'd0;
  localparam logic [17:0] GRN = 18'd38400;
  localparam logic [17:0] BEV = 18'd76800;
  localparam logic [17:0] BOD = 18'd96000;
`ifdef WRITE_OVERLAP_EN
  localparam int QUAD_PERIOD = 6;
`else
  localparam int QUAD_PERIOD = 10;
`endif

  logic        Clock_50 = 1'b0;
  logic        Resetn = 1'b1;
  logic        Start = 1'b0;
  logic        Pixel_valid = 1'b0;
  logic        Pixel_ready;
  logic [7:0]  Pixel_R = '0, Pixel_G = '0, Pixel_B = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        Busy, Done;
  logic [3:0]  debug_state;

  rgb_segment_sram_writer #(
    .RED_START_ADDRESS(RED), .GREEN_START_ADDRESS(GRN),
    .BLUE_EVEN_START_ADDRESS(BEV), .BLUE_ODD_START_ADDRESS(BOD),
    .NUM_QUADS(NQ)
  ) dut (
    .Clock_50(Clock_50), .Resetn(Resetn), .Start(Start),
    .Pixel_valid(Pixel_valid), .Pixel_ready(Pixel_ready),
    .Pixel_R(Pixel_R), .Pixel_G(Pixel_G), .Pixel_B(Pixel_B),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .Busy(Busy), .Done(Done),
    .debug_state(debug_state)
  );

  // ---------------- clock / reset ----------------
  always #10 Clock_50 = ~Clock_50;

  int cyc = 0;
  always @(posedge Clock_50) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  logic [15:0] sram_mem [logic [17:0]];
  int          w0_cyc[$];
  int          done_count = 0;
  logic        prev_we = 1'b0;
  logic [17:0] prev_addr = '0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Clock_50) begin
    if (Resetn) begin
      if (SRAM_we_n === 1'b0) begin
        obs_q.push_back({SRAM_address, SRAM_write_data});
        sram_mem[SRAM_address] = SRAM_write_data;
        if (SRAM_address < GRN && !SRAM_address[0]) w0_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_write: got addr %0d data %0h, expected no write", SRAM_address, SRAM_write_data);
        end else begin
          check("write", {SRAM_address, SRAM_write_data}, exp_q.pop_front());
        end
      end
      if (Done === 1'b1) begin
        done_count++;
        check("done_after_last_write", {15'd0, prev_we, prev_addr}, {15'd0, 1'b1, BOD + 18'(NQ - 1)});
        check("busy_low_with_done", {33'd0, Busy}, 34'd0);
      end
      prev_we   = (SRAM_we_n === 1'b0);
      prev_addr = SRAM_address;
    end
  end

  // ---------------- reference model ----------------
  logic [23:0] quad_px[4];
  int          quad_fill = 0;
  int          quad_idx = 0;

  // Expected write sequence for a completed quad.
  task automatic add_pixel(input logic [23:0] px);
    logic [17:0] q, q2;
    quad_px[quad_fill] = px;
    quad_fill++;
    if (quad_fill == 4) begin
      q  = 18'(quad_idx);
      q2 = 18'(2 * quad_idx);
      exp_q.push_back({RED + q2,         quad_px[0][23:16], quad_px[1][23:16]});
      exp_q.push_back({RED + q2 + 18'd1, quad_px[2][23:16], quad_px[3][23:16]});
      exp_q.push_back({GRN + q2,         quad_px[0][15:8],  quad_px[1][15:8]});
      exp_q.push_back({GRN + q2 + 18'd1, quad_px[2][15:8],  quad_px[3][15:8]});
      exp_q.push_back({BEV + q,          quad_px[0][7:0],   quad_px[2][7:0]});
      exp_q.push_back({BOD + q,          quad_px[1][7:0],   quad_px[3][7:0]});
      quad_fill = 0;
      quad_idx++;
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [17:0] a, input bit hi);
    logic [15:0] w;
    if (!sram_mem.exists(a)) return 8'hxx;
    w = sram_mem[a];
    return hi ? w[15:8] : w[7:0];
  endfunction

  // ---------------- driver ----------------
  task automatic push_pixel(input logic [23:0] px, input int stall_pct);
    int   waited;
    logic acc;
    waited = 0;
    acc    = 1'b0;
    while (stall_pct > 0 && $urandom_range(99, 0) < stall_pct) begin
      Pixel_valid = 1'b0;
      @(posedge Clock_50); #1;
    end
    Pixel_valid = 1'b1;
    {Pixel_R, Pixel_G, Pixel_B} = px;
    forever begin
      acc = Pixel_ready;
      @(posedge Clock_50); #1;
      if (acc) break;
      waited++;
      if (waited > 200) break;
    end
    Pixel_valid = 1'b0;
    if (acc) add_pixel(px);
    else check("ready_timeout", {33'd0, acc}, 34'd1);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(posedge Clock_50); #1;
    Start = 1'b0;
  endtask

  task automatic wait_obs(input int n, input string name);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 200) begin
      @(posedge Clock_50); #1;
      t++;
    end
    check(name, 34'(obs_q.size() >= n), 34'd1);
  endtask

  task automatic wait_done(input int n, input string name);
    int t;
    t = 0;
    while (done_count < n && t < 300) begin
      @(posedge Clock_50); #1;
      t++;
    end
    check(name, 34'(done_count), 34'(n));
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [3:0][23:0] px;
    logic [5:0][17:0] addr;
    logic [5:0][15:0] data;
  } vec_t;

  vec_t        tbl[2];
  logic [23:0] frame_px[4*NQ];

  initial begin
    int          t;
    logic [17:0] a;
    int          q, k;

    tbl[0].px   = {24'haabbcc, 24'h778899, 24'h445566, 24'h112233};
    tbl[0].addr = {18'd96000, 18'd76800, 18'd38401, 18'd38400, 18'd1, 18'd0};
    tbl[0].data = {16'h66cc, 16'h3399, 16'h88bb, 16'h2255, 16'h77aa, 16'h1144};
    tbl[1].px   = {24'h0a0b0c, 24'h070809, 24'h040506, 24'h010203};
    tbl[1].addr = {18'd96001, 18'd76801, 18'd38403, 18'd38402, 18'd3, 18'd2};
    tbl[1].data = {16'h060c, 16'h0309, 16'h080b, 16'h0205, 16'h070a, 16'h0104};

    // Reset values
    #3 Resetn = 1'b0;
    repeat (3) @(posedge Clock_50);
    #1;
    check("rst_addr",  34'(SRAM_address), 34'd0);
    check("rst_data",  34'(SRAM_write_data), 34'd0);
    check("rst_we_n",  34'(SRAM_we_n), 34'd1);
    check("rst_ready", 34'(Pixel_ready), 34'd0);
    check("rst_busy",  34'(Busy), 34'd0);
    check("rst_done",  34'(Done), 34'd0);
    Resetn = 1'b1;
    repeat (2) @(posedge Clock_50);
    #1;
    check("idle_no_ready", 34'(Pixel_ready), 34'd0);

    // Frame 1: table quads, then the rest with random valid stalls
    pulse_start();
    check("start_busy",  34'(Busy), 34'd1);
    check("start_ready", 34'(Pixel_ready), 34'd1);
    for (int v = 0; v < 2; v++) begin
      obs_q.delete();
      for (int j = 0; j < 4; j++) begin
        frame_px[4*v + j] = tbl[v].px[j];
        push_pixel(tbl[v].px[j], 0);
      end
      wait_obs(6, $sformatf("tbl%0d_writes_seen", v));
      for (int w = 0; w < 6; w++)
        if (w < obs_q.size())
          check($sformatf("tbl%0d_w%0d", v, w), obs_q[w], {tbl[v].addr[w], tbl[v].data[w]});
    end
    for (int i = 8; i < 4*NQ; i++) begin
      frame_px[i] = {8'(i), 8'(i >> 3) ^ 8'h5a, 8'(i * 7)};
      push_pixel(frame_px[i], 30);
      if (i == 23) pulse_start();  // must be ignored while busy
    end
    wait_done(1, "frame1_done");
    repeat (5) begin
      @(posedge Clock_50); #1;
      check("post_done_ready", 34'(Pixel_ready), 34'd0);
      check("post_done_busy",  34'(Busy), 34'd0);
    end
    check("frame1_done_once", 34'(done_count), 34'd1);
    check("frame1_exp_empty", 34'(exp_q.size()), 34'd0);

    // Golden packing: each pixel's bytes at their segment positions
    for (int i = 0; i < 4*NQ; i++) begin
      q = i / 4;
      k = i % 4;
      a = RED + 18'(2*q + k/2);
      check($sformatf("gold_r_%0d", i), 34'(rd_byte(a, (k % 2) == 0)), 34'(frame_px[i][23:16]));
      a = GRN + 18'(2*q + k/2);
      check($sformatf("gold_g_%0d", i), 34'(rd_byte(a, (k % 2) == 0)), 34'(frame_px[i][15:8]));
      a = ((k % 2) == 0) ? BEV + 18'(q) : BOD + 18'(q);
      check($sformatf("gold_b_%0d", i), 34'(rd_byte(a, k < 2)), 34'(frame_px[i][7:0]));
    end

    // Reset in the middle of a write group (state S_WRITE_2 while W1 is out)
    quad_idx = 0; quad_fill = 0;
    exp_q.delete(); obs_q.delete();
    pulse_start();
    for (int j = 0; j < 4; j++) push_pixel(24'($urandom), 0);
    t = 0;
    do begin
      @(negedge Clock_50);
      t++;
    end while (!(SRAM_we_n === 1'b0 && SRAM_address == RED + 18'd1) && t < 50);
    check("w1_seen_before_abort", 34'(t < 50), 34'd1);
    #1 Resetn = 1'b0;
    #1;
    check("abort_we_n",  34'(SRAM_we_n), 34'd1);
    check("abort_busy",  34'(Busy), 34'd0);
    check("abort_ready", 34'(Pixel_ready), 34'd0);
    exp_q.delete(); obs_q.delete();
    quad_idx = 0; quad_fill = 0;
    @(posedge Clock_50); #1;
    Resetn = 1'b1;
    repeat (4) begin
      @(posedge Clock_50); #1;
      check("abort_idle_busy",  34'(Busy), 34'd0);
      check("abort_idle_ready", 34'(Pixel_ready), 34'd0);
    end

    // Frame 2: restart at quad 0, valid held high, check quad period
    w0_cyc.delete();
    pulse_start();
    for (int i = 0; i < 4*NQ; i++) begin
      push_pixel(24'($urandom), 0);
      if (i == 3) begin
        wait_obs(1, "restart_first_write");
        if (obs_q.size() > 0) check("restart_addr0", 34'(obs_q[0][33:16]), 34'd0);
      end
    end
    wait_done(2, "frame2_done");
    check("frame2_exp_empty", 34'(exp_q.size()), 34'd0);
    for (int j = 4; j < 8; j++) begin
      if (w0_cyc.size() > j + 1) check($sformatf("quad_period_%0d", j), 34'(w0_cyc[j+1] - w0_cyc[j]), 34'(QUAD_PERIOD));
      else check("quad_period_samples", 34'(w0_cyc.size()), 34'(j + 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
